// File: rtl/ysyx_22041211_lsu.sv
// Load/store unit: one outstanding data-memory access at a time, byte-lane alignment,
// load extension and a registered writeback port toward WB.
//
// state | meaning
// IDLE  | no access in flight; a result may be held on valid_o waiting for ready_i (the DONE phase)
// REQ   | mem_req_o asserted with stable bus fields until mem_gnt_i
// WAIT  | granted, waiting for mem_rvalid_i or the response timeout
module ysyx_22041211_lsu #(
    parameter int DATA_LEN     = 32,
    parameter int RESP_TIMEOUT = 255
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  valid_i,
    output logic                  ready_o,
    input  logic [DATA_LEN-1:0]   alu_result_i,
    input  logic                  mem_wen_i,
    input  logic [DATA_LEN-1:0]   mem_wdata_i,
    input  logic [1:0]            store_type_i,
    input  logic [2:0]            load_type_i,
    input  logic                  wd_i,
    input  logic [4:0]            wreg_i,
    output logic                  mem_req_o,
    output logic                  mem_we_o,
    output logic [DATA_LEN-1:0]   mem_addr_o,
    output logic [DATA_LEN-1:0]   mem_wdata_o,
    output logic [3:0]            mem_wstrb_o,
    input  logic                  mem_gnt_i,
    input  logic                  mem_rvalid_i,
    input  logic [DATA_LEN-1:0]   mem_rdata_i,
    output logic                  valid_o,
    input  logic                  ready_i,
    output logic                  wd_o,
    output logic [4:0]            wreg_o,
    output logic [DATA_LEN-1:0]   wdata_o,
    output logic                  misalign_o,
    output logic                  err_o
);

    localparam int CNT_W = $clog2(RESP_TIMEOUT + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2
    } state_t;

    state_t              state;
    logic [CNT_W-1:0]    cnt;
    logic [1:0]          off_q;
    logic [2:0]          ld_q;
    logic                st_q;
    logic                wd_q;
    logic [4:0]          wreg_q;

    logic                accept;
    logic                is_store;
    logic                is_load;
    logic                is_mem;
    logic                misalign;
    logic [1:0]          off;
    logic [3:0]          strb;
    logic [DATA_LEN-1:0] rshift;
    logic [DATA_LEN-1:0] load_ext;

    assign ready_o  = (state == IDLE) && (!valid_o || ready_i);
    assign accept   = valid_i && ready_o;
    assign off      = alu_result_i[1:0];
    assign is_store = store_type_i != 2'b00;
    // A store wins over a simultaneously flagged load.
    assign is_load  = !is_store && (load_type_i != 3'b000);
    assign is_mem   = is_store || is_load;

    always_comb begin
        misalign = 1'b0;
        strb     = 4'b0000;
        if (is_store) begin
            case (store_type_i)
                2'b01: strb = 4'b0001 << off;
                2'b10: begin
                    strb     = 4'b0011 << off;
                    misalign = off[0];
                end
                default: begin
                    strb     = 4'b1111;
                    misalign = off != 2'b00;
                end
            endcase
        end else if (is_load) begin
            case (load_type_i)
                3'b010, 3'b101: misalign = off[0];
                3'b011:         misalign = off != 2'b00;
                default:        misalign = 1'b0;
            endcase
        end
    end

    always_comb begin
        rshift = mem_rdata_i >> {off_q, 3'b000};
        case (ld_q)
            3'b001:  load_ext = {{(DATA_LEN-8){rshift[7]}}, rshift[7:0]};
            3'b010:  load_ext = {{(DATA_LEN-16){rshift[15]}}, rshift[15:0]};
            3'b100:  load_ext = {{(DATA_LEN-8){1'b0}}, rshift[7:0]};
            3'b101:  load_ext = {{(DATA_LEN-16){1'b0}}, rshift[15:0]};
            default: load_ext = rshift;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            cnt         <= '0;
            off_q       <= 2'b00;
            ld_q        <= 3'b000;
            st_q        <= 1'b0;
            wd_q        <= 1'b0;
            wreg_q      <= 5'd0;
            mem_req_o   <= 1'b0;
            mem_we_o    <= 1'b0;
            mem_addr_o  <= '0;
            mem_wdata_o <= '0;
            mem_wstrb_o <= 4'b0000;
            valid_o     <= 1'b0;
            wd_o        <= 1'b0;
            wreg_o      <= 5'd0;
            wdata_o     <= '0;
            misalign_o  <= 1'b0;
            err_o       <= 1'b0;
        end else begin
            // WB consumed the held result; a completion below may refill it this same edge.
            if (valid_o && ready_i) begin
                valid_o    <= 1'b0;
                misalign_o <= 1'b0;
                err_o      <= 1'b0;
            end
            case (state)
                IDLE: begin
                    if (accept) begin
                        off_q  <= off;
                        ld_q   <= load_type_i;
                        st_q   <= is_store;
                        wd_q   <= wd_i;
                        wreg_q <= wreg_i;
                        if (!is_mem) begin
                            valid_o    <= 1'b1;
                            wd_o       <= wd_i;
                            wreg_o     <= wreg_i;
                            wdata_o    <= alu_result_i;
                            misalign_o <= 1'b0;
                            err_o      <= 1'b0;
                        end else if (misalign) begin
                            valid_o    <= 1'b1;
                            wd_o       <= 1'b0;
                            wreg_o     <= wreg_i;
                            wdata_o    <= '0;
                            misalign_o <= 1'b1;
                            err_o      <= 1'b0;
                        end else begin
                            state       <= REQ;
                            mem_req_o   <= 1'b1;
                            mem_we_o    <= mem_wen_i;
                            mem_addr_o  <= {alu_result_i[DATA_LEN-1:2], 2'b00};
                            mem_wdata_o <= mem_wdata_i << {off, 3'b000};
                            mem_wstrb_o <= strb;
                        end
                    end
                end
                REQ: begin
                    if (mem_gnt_i) begin
                        mem_req_o <= 1'b0;
                        cnt       <= '0;
                        if (mem_rvalid_i) begin
                            state      <= IDLE;
                            valid_o    <= 1'b1;
                            wd_o       <= st_q ? 1'b0 : wd_q;
                            wreg_o     <= wreg_q;
                            wdata_o    <= st_q ? '0 : load_ext;
                            misalign_o <= 1'b0;
                            err_o      <= 1'b0;
                        end else begin
                            state <= WAIT;
                        end
                    end
                end
                WAIT: begin
                    if (mem_rvalid_i) begin
                        state      <= IDLE;
                        valid_o    <= 1'b1;
                        wd_o       <= st_q ? 1'b0 : wd_q;
                        wreg_o     <= wreg_q;
                        wdata_o    <= st_q ? '0 : load_ext;
                        misalign_o <= 1'b0;
                        err_o      <= 1'b0;
                    end else if (cnt == CNT_W'(RESP_TIMEOUT)) begin
                        state      <= IDLE;
                        valid_o    <= 1'b1;
                        wd_o       <= 1'b0;
                        wreg_o     <= wreg_q;
                        wdata_o    <= '0;
                        misalign_o <= 1'b0;
                        err_o      <= 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ysyx_22041211_lsu.sv
// Scoreboard bench for the LSU: a driver issues directed and random instructions, a bus
// responder plays memory, and a monitor checks every WB handshake against a reference model.
module tb_ysyx_22041211_lsu;

    logic        clk = 1'b0;
    logic        rst;
    logic        valid_i, ready_o;
    logic [31:0] alu_result_i, mem_wdata_i;
    logic        mem_wen_i;
    logic [1:0]  store_type_i;
    logic [2:0]  load_type_i;
    logic        wd_i;
    logic [4:0]  wreg_i;
    logic        mem_req_o, mem_we_o;
    logic [31:0] mem_addr_o, mem_wdata_o;
    logic [3:0]  mem_wstrb_o;
    logic        mem_gnt_i, mem_rvalid_i;
    logic        rv_resp, rv_late;
    logic [31:0] mem_rdata_i;
    logic        valid_o, ready_i, wd_o, misalign_o, err_o;
    logic [4:0]  wreg_o;
    logic [31:0] wdata_o;

    assign mem_rvalid_i = rv_resp | rv_late;

    always #5 clk = ~clk;

    ysyx_22041211_lsu dut (
        .clk(clk), .rst(rst), .valid_i(valid_i), .ready_o(ready_o),
        .alu_result_i(alu_result_i), .mem_wen_i(mem_wen_i), .mem_wdata_i(mem_wdata_i),
        .store_type_i(store_type_i), .load_type_i(load_type_i), .wd_i(wd_i), .wreg_i(wreg_i),
        .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
        .mem_wdata_o(mem_wdata_o), .mem_wstrb_o(mem_wstrb_o), .mem_gnt_i(mem_gnt_i),
        .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i), .valid_o(valid_o),
        .ready_i(ready_i), .wd_o(wd_o), .wreg_o(wreg_o), .wdata_o(wdata_o),
        .misalign_o(misalign_o), .err_o(err_o)
    );

    typedef struct {
        logic [31:0] addr;
        logic        we;
        logic [3:0]  strb;
        logic [31:0] wdata;
        logic [31:0] rdata;
        int          gdly;
        int          rdly;
        bit          noresp;
    } bus_t;

    typedef struct {
        logic        wd;
        logic [4:0]  wreg;
        logic [31:0] wdata;
        logic        mis;
        logic        err;
    } res_t;

    bus_t bq[$];
    res_t rq[$];
    int   hs_cyc[$];
    int   errors = 0;
    int   checks = 0;
    int   cycle = 0;
    int   ready_mode = 1;

    always @(posedge clk) cycle <= cycle + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cycle);
        end
    endtask

    function automatic longint pw(input int n);
        return longint'(1) << n;
    endfunction

    // Reference model: derives the bus request and WB result from the instruction's meaning.
    function automatic void model(input logic [31:0] a, input logic [1:0] st, input logic [2:0] ld,
                                  input logic [31:0] sd, input logic wen, input logic wd,
                                  input logic [4:0] wreg, input logic [31:0] rdata,
                                  input int gd, input int rd, input bit nr);
        int      off  = int'(a % 4);
        int      size;
        bit      store = (st != 0);
        bit      mem   = store || (ld != 0);
        longint  v;
        res_t    r;
        bus_t    b;
        if (store) size = (st == 1) ? 1 : (st == 2) ? 2 : 4;
        else       size = (ld == 1 || ld == 4) ? 1 : (ld == 2 || ld == 5) ? 2 : 4;
        r.wreg = wreg; r.mis = 0; r.err = 0; r.wd = 0; r.wdata = 0;
        if (!mem) begin
            r.wd = wd; r.wdata = a;
            rq.push_back(r);
            return;
        end
        if (off % size != 0) begin
            r.mis = 1;
            rq.push_back(r);
            return;
        end
        b.addr = a - 32'(off);
        b.we = wen; b.strb = 4'b0000;
        if (store) for (int i = 0; i < size; i++) b.strb[off + i] = 1'b1;
        b.wdata = 32'(longint'(sd) * pw(8 * off));
        b.rdata = rdata; b.gdly = gd; b.rdly = rd; b.noresp = nr;
        if (nr) r.err = 1;
        else if (!store) begin
            v = (longint'(rdata) / pw(8 * off)) % pw(8 * size);
            if ((ld == 1 || ld == 2) && v >= pw(8 * size - 1)) v = v - pw(8 * size);
            r.wdata = 32'(v);
            r.wd = wd;
        end
        bq.push_back(b);
        rq.push_back(r);
    endfunction

    task automatic send(input logic [31:0] a, input logic [1:0] st, input logic [2:0] ld,
                        input logic [31:0] sd, input logic wen, input logic wd,
                        input logic [4:0] wreg, input logic [31:0] rdata,
                        input int gd, input int rd, input bit nr);
        int n = 0;
        model(a, st, ld, sd, wen, wd, wreg, rdata, gd, rd, nr);
        valid_i = 1'b1; alu_result_i = a; store_type_i = st; load_type_i = ld;
        mem_wdata_i = sd; mem_wen_i = wen; wd_i = wd; wreg_i = wreg;
        @(negedge clk);
        while (!ready_o && n < 2000) begin
            n++;
            @(negedge clk);
        end
        if (!ready_o) begin
            checks++; errors++;
            $display("FAIL accept_timeout: ready_o stayed %b, required 1", ready_o);
        end
        @(posedge clk);
        #1;
        valid_i = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while ((rq.size() != 0 || bq.size() != 0) && n < 3000) begin
            @(posedge clk);
            n++;
        end
        chk("drain_outstanding", 32'(rq.size() + bq.size()), 32'd0);
        @(posedge clk);
        #1;
    endtask

    // WB-side ready generator
    initial begin
        ready_i = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            ready_i = (ready_mode == 1) ? 1'b1 : ($urandom_range(0, 3) != 0);
        end
    end

    // Monitor: pops an expectation on each WB handshake and checks that stalled outputs hold.
    initial begin : monitor
        bit   held = 0;
        res_t h, e;
        forever begin
            @(negedge clk);
            if (rst) begin
                held = 0;
            end else if (valid_o) begin
                if (held) begin
                    chk("hold_wdata", wdata_o, h.wdata);
                    chk("hold_wd", 32'(wd_o), 32'(h.wd));
                    chk("hold_wreg", 32'(wreg_o), 32'(h.wreg));
                end
                if (ready_i) begin
                    held = 0;
                    hs_cyc.push_back(cycle);
                    if (rq.size() == 0) begin
                        checks++; errors++;
                        $display("FAIL unexpected_valid: valid_o=1 with wdata %h, required no result", wdata_o);
                    end else begin
                        e = rq.pop_front();
                        chk("wb_wdata", wdata_o, e.wdata);
                        chk("wb_wd", 32'(wd_o), 32'(e.wd));
                        chk("wb_wreg", 32'(wreg_o), 32'(e.wreg));
                        chk("wb_misalign", 32'(misalign_o), 32'(e.mis));
                        chk("wb_err", 32'(err_o), 32'(e.err));
                    end
                end else begin
                    held = 1;
                    h.wdata = wdata_o; h.wd = wd_o; h.wreg = wreg_o;
                end
            end else begin
                held = 0;
            end
        end
    end

    // Memory responder: checks each request against the model, then grants and responds.
    initial begin : responder
        bus_t b;
        mem_gnt_i = 1'b0; rv_resp = 1'b0; mem_rdata_i = 32'h0;
        forever begin
            @(negedge clk);
            if (!rst && mem_req_o) begin
                if (bq.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_req: mem_req_o=1 addr %h, required no request", mem_addr_o);
                end else begin
                    b = bq.pop_front();
                    chk("req_addr", mem_addr_o, b.addr);
                    chk("req_we", 32'(mem_we_o), 32'(b.we));
                    chk("req_strb", 32'(mem_wstrb_o), 32'(b.strb));
                    if (b.we) chk("req_wdata", mem_wdata_o, b.wdata);
                    chk("busy_ready", 32'(ready_o), 32'd0);
                    for (int i = 0; i < b.gdly; i++) begin
                        @(negedge clk);
                        chk("req_hold", 32'(mem_req_o), 32'd1);
                        chk("req_hold_addr", mem_addr_o, b.addr);
                        chk("req_hold_strb", 32'(mem_wstrb_o), 32'(b.strb));
                        chk("req_hold_ready", 32'(ready_o), 32'd0);
                    end
                    mem_gnt_i = 1'b1;
                    if (b.rdly == 0 && !b.noresp) begin
                        rv_resp = 1'b1; mem_rdata_i = b.rdata;
                    end
                    @(negedge clk);
                    mem_gnt_i = 1'b0; rv_resp = 1'b0; mem_rdata_i = $urandom;
                    if (!b.noresp && b.rdly > 0) begin
                        repeat (b.rdly - 1) @(negedge clk);
                        chk("wait_valid", 32'(valid_o), 32'd0);
                        rv_resp = 1'b1; mem_rdata_i = b.rdata;
                        @(negedge clk);
                        rv_resp = 1'b0; mem_rdata_i = $urandom;
                    end
                end
            end
        end
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    initial begin : main
        int n;
        logic [1:0]  st;
        logic [2:0]  ld;
        logic [31:0] sd, a;
        rst = 1'b1; rv_late = 1'b0;
        valid_i = 1'b0; alu_result_i = '0; mem_wdata_i = '0; mem_wen_i = 1'b0;
        store_type_i = '0; load_type_i = '0; wd_i = 1'b0; wreg_i = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ready", 32'(ready_o), 32'd1);
        chk("rst_valid", 32'(valid_o), 32'd0);
        chk("rst_req", 32'(mem_req_o), 32'd0);
        chk("rst_wdata", wdata_o, 32'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Non-memory pass-through, then a burst that must complete one per cycle
        ready_mode = 1;
        send(32'h1234, 2'b00, 3'b000, 0, 0, 1, 5, 0, 0, 0, 0);
        for (int i = 0; i < 5; i++) send(32'h100 + 32'(i), 2'b00, 3'b000, 0, 0, 1, 5'(i + 1), 0, 0, 0, 0);
        drain();
        n = hs_cyc.size();
        chk("throughput", 32'(hs_cyc[n - 1] - hs_cyc[n - 5]), 32'd4);

        // Byte store to the top lane
        send(32'h8000_0003, 2'b01, 3'b000, 32'h0000_00AB, 1, 1, 7, 0, 1, 1, 0);
        // Sub-word loads from the upper half-word
        send(32'h102, 2'b00, 3'b001, 0, 0, 1, 8,  32'h80F1_0000, 0, 1, 0);
        send(32'h102, 2'b00, 3'b100, 0, 0, 1, 9,  32'h80F1_0000, 1, 0, 0);
        send(32'h102, 2'b00, 3'b010, 0, 0, 1, 10, 32'h80F1_0000, 2, 2, 0);
        send(32'h102, 2'b00, 3'b101, 0, 0, 1, 11, 32'h80F1_0000, 0, 0, 0);
        // Misaligned word load and half store: no bus traffic
        send(32'h201, 2'b00, 3'b011, 0, 0, 1, 12, 0, 0, 0, 0);
        send(32'h003, 2'b10, 3'b000, 32'h0000_BEEF, 1, 1, 13, 0, 0, 0, 0);
        drain();

        // Slow grant, slow response, stalling WB; then same-cycle grant and response
        ready_mode = 0;
        send(32'h0000_0400, 2'b00, 3'b011, 0, 0, 1, 14, 32'hCAFE_F00D, 3, 5, 0);
        send(32'h0000_0404, 2'b11, 3'b000, 32'h1357_9BDF, 1, 1, 15, 0, 3, 5, 0);
        send(32'h0000_0408, 2'b00, 3'b011, 0, 0, 1, 16, 32'h0BAD_BEEF, 0, 0, 0);
        drain();

        // Response timeout
        send(32'h0000_0500, 2'b00, 3'b011, 0, 0, 1, 17, 0, 1, 0, 1);
        drain();

        // Randomized mix
        for (int k = 0; k < 150; k++) begin
            a  = $urandom;
            sd = $urandom;
            st = 2'b00; ld = 3'b000;
            case ($urandom_range(0, 2))
                0: ;
                1: st = 2'($urandom_range(1, 3));
                default: ld = 3'($urandom_range(1, 5));
            endcase
            if ($urandom_range(0, 1) == 1) a[1:0] = 2'b00;
            if (st == 2'b01) sd = sd & 32'hFF;
            if (st == 2'b10) sd = sd & 32'hFFFF;
            send(a, st, ld, sd, st != 2'b00, 1'($urandom), 5'($urandom), $urandom,
                 $urandom_range(0, 3), $urandom_range(0, 5), 0);
        end
        drain();

        // Reset in the middle of WAIT, followed by a late response that must be ignored
        ready_mode = 1;
        send(32'h0000_0600, 2'b00, 3'b011, 0, 0, 1, 18, 0, 0, 0, 1);
        repeat (10) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        chk("mid_rst_ready", 32'(ready_o), 32'd1);
        chk("mid_rst_valid", 32'(valid_o), 32'd0);
        chk("mid_rst_req", 32'(mem_req_o), 32'd0);
        chk("mid_rst_err", 32'(err_o), 32'd0);
        rq.delete();
        bq.delete();
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        rv_late = 1'b1;
        @(negedge clk);
        rv_late = 1'b0;
        repeat (3) @(negedge clk);
        chk("late_rvalid_ignored", 32'(valid_o), 32'd0);
        chk("late_rvalid_ready", 32'(ready_o), 32'd1);
        @(posedge clk);
        #1;
        send(32'hA5A5_0001, 2'b00, 3'b000, 0, 0, 1, 19, 0, 0, 0, 0);
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ysyx_22041211_lsu.md
Name: ysyx_22041211_LSU

Overview:
Memory-access stage that consumes EXE results: ALU address, store data, store/load type, and writeback tag. Issues the load or store on a single-outstanding data-memory request/response bus, with byte-lane alignment. Sign- or zero-extends load data and hands the writeback to WB. Non-memory instructions pass through with one-cycle latency.

Parameters:
DATA_LEN, 32, data/address width (the block supports only 32).
RESP_TIMEOUT, 255, cycles in WAIT before an access is aborted with err_o.

Ports:
clk  input  1  clock, rising edge
rst  input  1  asynchronous active-high reset
valid_i  input  1  EXE result valid
ready_o  output  1  LSU can accept from EXE
alu_result_i  input  32  effective address, or ALU result for non-memory instructions
mem_wen_i  input  1  store request
mem_wdata_i  input  32  store data, lane 0-aligned, pre-masked
store_type_i  input  2  00 none, 01 SB, 10 SH, 11 SW
load_type_i  input  3  000 none, 001 LB, 010 LH, 011 LW, 100 LBU, 101 LHU
wd_i  input  1  register-write enable
wreg_i  input  5  destination register
mem_req_o  output  1  bus request
mem_we_o  output  1  1 = write
mem_addr_o  output  32  word-aligned address, {addr[31:2],2'b00}
mem_wdata_o  output  32  lane-shifted store data
mem_wstrb_o  output  4  byte strobes
mem_gnt_i  input  1  request accepted this cycle
mem_rvalid_i  input  1  response (read data or write ack)
mem_rdata_i  input  32  read data
valid_o  output  1  WB result valid
ready_i  input  1  WB accepts
wd_o  output  1  register-write enable to WB
wreg_o  output  5  destination register to WB
wdata_o  output  32  load result or passed-through ALU result
misalign_o  output  1  accompanies valid_o: misaligned access, no bus traffic
err_o  output  1  accompanies valid_o: response timeout

Behaviour:
- Reset: state IDLE; all outputs 0 except ready_o=1; timeout counter 0. Asynchronous assert, synchronous-edge release.
- ready_o = (state==IDLE) && (!valid_o || ready_i).
- Accept = valid_i && ready_o. On accept, latch all inputs and addr[1:0].
- Misalign: SH/LH/LHU with addr[0]=1; SW/LW with addr[1:0]!=0.
- Misaligned accept: go to DONE next cycle with misalign_o=1, wd_o=0, no mem_req_o.
- Non-memory accept (store_type=00, load_type=000): DONE next cycle, wdata_o=alu_result.
- Memory accept: enter REQ next cycle. mem_req_o=1 and bus fields stable until mem_gnt_i.
- Strobes: SB 0001<<off, SH 0011<<off, SW 1111. mem_wdata_o = mem_wdata_i << (8*off).
- mem_we_o=mem_wen_i. store_type nonzero with load_type nonzero is illegal; store takes priority.
- REQ: mem_gnt_i -> WAIT. mem_gnt_i && mem_rvalid_i in the same cycle is legal: go straight to DONE and capture data.
- WAIT: mem_rvalid_i -> DONE, capture rdata. Counter increments each WAIT cycle. Counter==RESP_TIMEOUT -> DONE with err_o=1, wd_o=0. Responses arriving after a timeout, outside WAIT, are ignored.
- Load extract: byte = rdata>>(8*off). LB sign-extends [7:0], LBU zero-extends. LH/LHU same for [15:0]. LW takes the whole word.
- Stores: wdata_o=0, wd_o forced 0.
- DONE: valid_o=1, all outputs held until ready_i. On ready_i: IDLE, valid_o drops next cycle unless a new accept completes.
- Non-memory instructions achieve throughput of 1 per cycle, because IDLE accept is allowed while valid_o && ready_i.
- Only one access outstanding. Reset mid-REQ/WAIT drops the access immediately; a late mem_rvalid_i after reset is ignored.

Test Plan:
- Non-memory: alu_result=0x1234, wd=1, wreg=5, ready_i=1 -> valid_o one cycle later with wdata_o=0x1234, wreg_o=5. Back-to-back sustains 1/cycle.
- SB addr 0x80000003, wdata 0x000000AB -> mem_addr 0x80000000, wstrb 1000, mem_wdata 0xAB000000, mem_we 1. After ack, valid_o with wd_o=0.
- LB/LBU/LH/LHU addr 0x102, rdata 0x80F1_0000 -> LB 0xFFFFFFF1, LBU 0x000000F1, LH 0xFFFF80F1, LHU 0x000080F1.
- LW addr 0x201 -> misalign_o=1, no mem_req_o. SH addr 0x3 -> misalign_o=1.
- mem_gnt_i delayed 3 cycles, mem_rvalid_i 5 cycles later, ready_i low 2 cycles: request fields stable throughout, output held, ready_o=0 throughout. Same-cycle gnt+rvalid -> DONE next cycle.
- No response for 255 cycles -> err_o=1, wd_o=0. Reset asserted in WAIT -> all outputs at reset values immediately, ready_o=1.
